alu_arbiter: RTL and testbench



---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_arbiter_if.sv | 45 ++++
 rtl/alu_rr_pick.sv | 42 ++++
 rtl/alu_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU arbiter slice: ALUOp encodings, the
// arbiter FSM state type and the default datapath width.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   localparam logic [3:0] OP_PASSA = 4'b1010;
   localparam logic [3:0] OP_AND   = 4'b1000;
   localparam logic [3:0] OP_NOR   = 4'b0001;
   localparam logic [3:0] OP_OR    = 4'b1110;
   localparam logic [3:0] OP_XNOR  = 4'b1001;
   localparam logic [3:0] OP_XOR   = 4'b0110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

endpackage : alu_pkg

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the two requester ports, the response handshake, the shared-ALU
// drive/result signals and the busy flag.
//   slave  : arbiter side (consumes requests, drives the ALU and responses)
//   master : environment side (requesters + shared ALU)
// Signals: req_valid/req_ready[1:0], req_op0/1, req_a0/1, req_b0/1,
//          resp_valid/resp_ready[1:0], resp_data, alu_op, alu_a, alu_b,
//          alu_result, busy.
// -----------------------------------------------------------------------------
interface alu_arbiter_if
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
);
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [3:0]       req_op0;
   logic [3:0]       req_op1;
   logic [WIDTH-1:0] req_a0;
   logic [WIDTH-1:0] req_a1;
   logic [WIDTH-1:0] req_b0;
   logic [WIDTH-1:0] req_b1;
   logic [1:0]       resp_valid;
   logic [1:0]       resp_ready;
   logic [WIDTH-1:0] resp_data;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_result;
   logic             busy;

   modport slave (
      input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
      input  resp_ready, alu_result,
      output req_ready, resp_valid, resp_data, alu_op, alu_a, alu_b, busy
   );

   modport master (
      output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
      output resp_ready, alu_result,
      input  req_ready, resp_valid, resp_data, alu_op, alu_a, alu_b, busy
   );

endinterface : alu_arbiter_if

// File: rtl/alu_rr_pick.sv
// -----------------------------------------------------------------------------
// alu_rr_pick
// Combinational two-way grant picker.
//   i_valid[1:0] : per-port request valid
//   i_ptr        : round-robin priority pointer (port favoured on contention)
//   o_grant[1:0] : one-hot grant (zero when nothing is valid)
//   o_any        : at least one port is valid
// Build option ALU_ARB_RR_EN: defined -> round-robin on contention using
// i_ptr; undefined -> fixed priority, port 0 wins and i_ptr is ignored.
// -----------------------------------------------------------------------------
module alu_rr_pick (
   input  logic [1:0] i_valid,
   input  logic       i_ptr,
   output logic [1:0] o_grant,
   output logic       o_any
);

`ifdef ALU_ARB_RR_EN
   always_comb begin
      o_grant = i_valid;
      // Contention is the only case where the pointer matters.
      if (i_valid == 2'b11) begin
         o_grant = i_ptr ? 2'b10 : 2'b01;
      end
   end
`else
   logic w_unused_ptr;
   assign w_unused_ptr = i_ptr;

   always_comb begin
      o_grant = 2'b00;
      if (i_valid[0]) begin
         o_grant = 2'b01;
      end else if (i_valid[1]) begin
         o_grant = 2'b10;
      end
   end
`endif

   assign o_any = |i_valid;

endmodule : alu_rr_pick

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two requesters. One operation is
// accepted in IDLE, the ALU is driven from registered operands for one EXEC
// cycle, the result is captured and returned to the owning port in RESP.
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset (drops any in-flight op)
//   bus  : alu_arbiter_if.slave (requests, responses, ALU drive, busy)
// Build option ALU_ARB_RR_EN: defined -> round-robin grant with a 1-bit
// pointer; undefined -> fixed priority to port 0, no pointer register.
// -----------------------------------------------------------------------------
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   alu_arbiter_if.slave bus
);

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   logic             r_owner;
   logic [3:0]       r_alu_op;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [WIDTH-1:0] r_resp_data;

   logic [1:0]       w_grant;
   logic             w_any;
   logic             w_ptr;
   logic             w_accept;
   logic [1:0]       w_req_ready;
   logic [1:0]       w_resp_valid;
   logic             w_busy;

`ifdef ALU_ARB_RR_EN
   logic r_ptr;

   // After an accept the pointer favours the port that was not granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= 1'b0;
      end else if (w_accept) begin
         r_ptr <= ~w_grant[1];
      end
   end

   assign w_ptr = r_ptr;
`else
   assign w_ptr = 1'b0;
`endif

   alu_rr_pick u_pick (
      .i_valid (bus.req_valid),
      .i_ptr   (w_ptr),
      .o_grant (w_grant),
      .o_any   (w_any)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and handshake outputs
   always_comb begin
      w_state_nxt  = r_state;
      w_req_ready  = 2'b00;
      w_resp_valid = 2'b00;
      w_busy       = 1'b1;
      w_accept     = 1'b0;
      case (r_state)
         IDLE: begin
            w_busy      = 1'b0;
            w_req_ready = w_grant;
            // The granted port is always valid, so any valid bit is a handshake.
            if (w_any) begin
               w_accept    = 1'b1;
               w_state_nxt = EXEC;
            end
         end
         EXEC: begin
            w_state_nxt = RESP;
         end
         RESP: begin
            w_resp_valid = r_owner ? 2'b10 : 2'b01;
            if (bus.resp_ready[r_owner]) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Operand capture on accept, result capture in EXEC; held otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner     <= 1'b0;
         r_alu_op    <= OP_PASSA;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_resp_data <= '0;
      end else begin
         if (w_accept) begin
            r_owner  <= w_grant[1];
            r_alu_op <= w_grant[1] ? bus.req_op1 : bus.req_op0;
            r_alu_a  <= w_grant[1] ? bus.req_a1  : bus.req_a0;
            r_alu_b  <= w_grant[1] ? bus.req_b1  : bus.req_b0;
         end
         if (r_state == EXEC) begin
            r_resp_data <= bus.alu_result;
         end
      end
   end

   assign bus.req_ready  = w_req_ready;
   assign bus.resp_valid = w_resp_valid;
   assign bus.resp_data  = r_resp_data;
   assign bus.alu_op     = r_alu_op;
   assign bus.alu_a      = r_alu_a;
   assign bus.alu_b      = r_alu_b;
   assign bus.busy       = w_busy;

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter. Provides a small combinational ALU on
// the shared-ALU side, applies a table of single-port transactions and then
// hand-written sequences for contention, backpressure, non-owner resp_ready
// and reset during EXEC. Expected grant order follows ALU_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
   import alu_pkg::*;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   alu_arbiter_if #(.WIDTH(32)) bus ();

   alu_arbiter #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      case (op)
         OP_AND:   return a & b;
         OP_OR:    return a | b;
         OP_XOR:   return a ^ b;
         OP_NOR:   return ~(a | b);
         OP_XNOR:  return ~(a ^ b);
         OP_PASSA: return a;
         default:  return 32'h0;
      endcase
   endfunction

   assign bus.alu_result = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);

   function automatic logic [1:0] onehot(input logic p);
      return p ? 2'b10 : 2'b01;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   typedef struct {
      logic        port;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[7];

   // One single-port transaction with immediate resp_ready, checked per cycle.
   task automatic txn(input logic port, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp);
      @(negedge clk);
      bus.resp_ready = 2'b11;
      if (port) begin
         bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b;
      end else begin
         bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b;
      end
      bus.req_valid = onehot(port);
      #1;
      chk("idle_req_ready", bus.req_ready, onehot(port));
      chk("idle_busy", bus.busy, 1'b0);
      @(negedge clk);
      bus.req_valid = 2'b00;
      #1;
      chk("exec_alu_op", bus.alu_op, op);
      chk("exec_alu_a", bus.alu_a, a);
      chk("exec_alu_b", bus.alu_b, b);
      chk("exec_resp_valid", bus.resp_valid, 2'b00);
      chk("exec_busy", bus.busy, 1'b1);
      @(negedge clk);
      #1;
      chk("resp_valid", bus.resp_valid, onehot(port));
      chk("resp_data", bus.resp_data, exp);
      chk("resp_req_ready", bus.req_ready, 2'b00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  g;
      logic [31:0] d;
      n_tests = 0;
      n_fail  = 0;

      vecs[0] = '{1'b0, OP_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
      vecs[1] = '{1'b1, OP_OR,    32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
      vecs[2] = '{1'b0, OP_XOR,   32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555};
      vecs[3] = '{1'b1, OP_NOR,   32'h0F0F_0F0F, 32'hF0F0_F000, 32'h0000_00F0};
      vecs[4] = '{1'b0, 4'b0011,  32'h1234_5678, 32'h0000_FFFF, 32'h0000_0000};
      vecs[5] = '{1'b1, OP_XNOR,  32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF};
      vecs[6] = '{1'b0, OP_PASSA, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF};

      rst = 1'b1;
      bus.req_valid  = 2'b00;
      bus.resp_ready = 2'b00;
      bus.req_op0 = 4'h0; bus.req_op1 = 4'h0;
      bus.req_a0 = '0; bus.req_a1 = '0; bus.req_b0 = '0; bus.req_b1 = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req_ready", bus.req_ready, 2'b00);
      chk("rst_resp_valid", bus.resp_valid, 2'b00);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_resp_data", bus.resp_data, 32'h0);
      chk("rst_alu_a", bus.alu_a, 32'h0);
      chk("rst_alu_b", bus.alu_b, 32'h0);
      chk("rst_alu_op", bus.alu_op, 4'b1010);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         txn(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      end

      // Reset asserted while in EXEC: op dropped, no response afterwards.
      @(negedge clk);
      bus.resp_ready = 2'b11;
      bus.req_op0 = OP_XOR; bus.req_a0 = 32'hAAAA_AAAA; bus.req_b0 = 32'hFFFF_FFFF;
      bus.req_valid = 2'b01;
      @(negedge clk);
      bus.req_valid = 2'b00;
      #1;
      chk("rexec_alu_op", bus.alu_op, OP_XOR);
      rst = 1'b1;
      #1;
      chk("rexec_resp_valid", bus.resp_valid, 2'b00);
      chk("rexec_busy", bus.busy, 1'b0);
      chk("rexec_alu_op_rst", bus.alu_op, 4'b1010);
      chk("rexec_resp_data", bus.resp_data, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("rexec_no_resp", bus.resp_valid, 2'b00);
         chk("rexec_idle", bus.busy, 1'b0);
      end

      // Both ports valid continuously.
      bus.req_op0 = OP_XOR; bus.req_a0 = 32'hAAAA_AAAA; bus.req_b0 = 32'hFFFF_FFFF;
      bus.req_op1 = OP_OR;  bus.req_a1 = 32'h0000_0001; bus.req_b1 = 32'h0000_0002;
      for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
         g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
         g = 2'b01;
`endif
         d = (g == 2'b01) ? 32'h5555_5555 : 32'h0000_0003;
         @(negedge clk);
         bus.req_valid = 2'b11;
         #1;
         chk("both_grant", bus.req_ready, g);
         @(negedge clk);
         #1;
         chk("both_exec_ready", bus.req_ready, 2'b00);
         @(negedge clk);
         #1;
         chk("both_resp_valid", bus.resp_valid, g);
         chk("both_resp_data", bus.resp_data, d);
      end
      @(negedge clk);
      bus.req_valid = 2'b10;
      #1;
      chk("drop0_grant1", bus.req_ready, 2'b10);
      @(negedge clk);
      bus.req_valid = 2'b00;
      @(negedge clk);
      #1;
      chk("drop0_resp_valid", bus.resp_valid, 2'b10);
      chk("drop0_resp_data", bus.resp_data, 32'h0000_0003);

      // Backpressure on port 0 while port 1 waits.
      @(negedge clk);
      bus.resp_ready = 2'b00;
      bus.req_op0 = OP_AND; bus.req_a0 = 32'hF0F0_F0F0; bus.req_b0 = 32'hFF00_FF00;
      bus.req_valid = 2'b01;
      #1;
      chk("bp_accept", bus.req_ready, 2'b01);
      @(negedge clk);
      bus.req_valid = 2'b10;
      #1;
      chk("bp_exec_ready", bus.req_ready, 2'b00);
      @(negedge clk);
      #1;
      chk("bp_resp_valid", bus.resp_valid, 2'b01);
      chk("bp_resp_data", bus.resp_data, 32'hF000_F000);
      repeat (5) begin
         @(negedge clk);
         #1;
         chk("bp_hold_valid", bus.resp_valid, 2'b01);
         chk("bp_hold_data", bus.resp_data, 32'hF000_F000);
         chk("bp_hold_op", bus.alu_op, OP_AND);
         chk("bp_hold_a", bus.alu_a, 32'hF0F0_F0F0);
         chk("bp_hold_ready", bus.req_ready, 2'b00);
      end
      @(negedge clk);
      bus.resp_ready = 2'b01;
      #1;
      chk("bp_rr_ready", bus.req_ready, 2'b00);
      chk("bp_rr_valid", bus.resp_valid, 2'b01);
      @(negedge clk);
      #1;
      chk("bp_next_accept", bus.req_ready, 2'b10);
      chk("bp_next_no_resp", bus.resp_valid, 2'b00);

      // Port 1 owns RESP; resp_ready on port 0 only must be ignored.
      @(negedge clk);
      bus.req_valid = 2'b00;
      #1;
      chk("no_exec_op", bus.alu_op, OP_OR);
      @(negedge clk);
      #1;
      chk("no_resp_valid", bus.resp_valid, 2'b10);
      chk("no_resp_data", bus.resp_data, 32'h0000_0003);
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("no_stay_valid", bus.resp_valid, 2'b10);
         chk("no_stay_busy", bus.busy, 1'b1);
      end
      @(negedge clk);
      bus.resp_ready = 2'b10;
      #1;
      chk("no_last_valid", bus.resp_valid, 2'b10);
      @(negedge clk);
      #1;
      chk("no_done_busy", bus.busy, 1'b0);
      chk("no_done_valid", bus.resp_valid, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_alu_arbiter
